// File: rtl/line_refill_pkg.sv
// Shared types and defaults for the line refill engine.
// Provides the FSM state type, default geometry, and the beat address helper.
package refill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } refill_state_t;

  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned BUS_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 128;

  // Word address of a beat inside a line. The base has its offset bits cleared,
  // so OR-ing the beat in can never carry into the index/tag bits.
  function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                            input logic [63:0] beat,
                                            input int unsigned word_sh);
    return base | (beat << word_sh);
  endfunction

endpackage

// File: rtl/line_refill_if.sv
// Handshake bundle between the refill engine, the miss logic, the read bus
// and the data-array write port. The engine connects through the slave modport;
// the surrounding logic (or a bench) connects through the master modport.
interface line_refill_if
  import refill_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned BUS_W   = BUS_W_DEF,
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned INDEX_W = $clog2(DEPTH_DEF)
);

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_resp_valid;
  logic [BUS_W-1:0]  bus_resp_data;

  logic               ram_we;
  logic [INDEX_W-1:0] ram_a;
  logic [LINE_W-1:0]  ram_di;
  logic               fill_done;

  logic              cw_valid;
  logic [BUS_W-1:0]  cw_data;

  modport master (
    output miss_valid, miss_addr,
    output bus_req_ready, bus_resp_valid, bus_resp_data,
    input  miss_ready,
    input  bus_req_valid, bus_req_addr,
    input  ram_we, ram_a, ram_di, fill_done,
    input  cw_valid, cw_data
  );

  modport slave (
    input  miss_valid, miss_addr,
    input  bus_req_ready, bus_resp_valid, bus_resp_data,
    output miss_ready,
    output bus_req_valid, bus_req_addr,
    output ram_we, ram_a, ram_di, fill_done,
    output cw_valid, cw_data
  );

endinterface

// File: rtl/line_refill.sv
// Cache line refill engine: takes one line miss, fetches the line as bus-width
// beats (one read outstanding at a time), assembles it, and writes the whole
// line into the LUT-RAM data array in a single cycle.
// Build option: define LINE_REFILL_CWF_EN for critical-word-first fetch order
// and the cw_valid/cw_data early-word pulse; otherwise beats are fetched in
// order from beat 0 and the critical-word outputs are tied to zero.
module line_refill
  import refill_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned BUS_W   = BUS_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned INDEX_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  line_refill_if.slave rif
);

  localparam int unsigned BEATS   = LINE_W / BUS_W;
  localparam int unsigned OFF_W   = $clog2(LINE_W / 8);
  localparam int unsigned WORD_SH = $clog2(BUS_W / 8);
  localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W   = $clog2(BEATS) + 1;

  refill_state_t      state_q;
  logic               miss_ready_q;
  logic               req_valid_q;
  logic               ram_we_q;
  logic [INDEX_W-1:0] index_q;
  logic [ADDR_W-1:0]  base_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  beat_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [LINE_W-1:0]  buf_q;
  logic [BEAT_W-1:0]  start_beat;
  logic               capture;
  logic [63:0]        req_addr_full;
  logic               unused_bits;

  // A response only counts while the engine is actually waiting for one.
  assign capture = (state_q == WAIT) && rif.bus_resp_valid;

`ifdef LINE_REFILL_CWF_EN
  assign start_beat = rif.miss_addr[OFF_W-1:WORD_SH];
`else
  assign start_beat = '0;
`endif

  // Next beat wraps modulo BEATS; the count tracks beats captured so far.
  always_comb begin
    beat_d = beat_q + 1'b1;
    if (beat_q == BEAT_W'(BEATS - 1)) begin
      beat_d = '0;
    end
    cnt_d = cnt_q + 1'b1;
  end

  // Refill sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      miss_ready_q <= 1'b1;
      req_valid_q  <= 1'b0;
      ram_we_q     <= 1'b0;
      index_q      <= '0;
      base_q       <= '0;
      beat_q       <= '0;
      cnt_q        <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rif.miss_valid) begin
            index_q      <= rif.miss_addr[OFF_W +: INDEX_W];
            base_q       <= {rif.miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            beat_q       <= start_beat;
            cnt_q        <= '0;
            miss_ready_q <= 1'b0;
            req_valid_q  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (rif.bus_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (rif.bus_resp_valid) begin
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
            if (cnt_d == CNT_W'(BEATS)) begin
              ram_we_q <= 1'b1;
              state_q  <= WRITE;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        WRITE: begin
          miss_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          miss_ready_q <= 1'b1;
          req_valid_q  <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Line buffer: each captured beat lands in the slot of its word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q[int'(beat_q) * BUS_W +: BUS_W] <= rif.bus_resp_data;
    end
  end

`ifdef LINE_REFILL_CWF_EN
  logic             cw_valid_q;
  logic [BUS_W-1:0] cw_data_q;

  // Critical word: pulse once after the first beat of the fill is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_valid_q <= 1'b0;
      cw_data_q  <= '0;
    end else begin
      cw_valid_q <= capture && (cnt_q == '0);
      if (capture && (cnt_q == '0)) begin
        cw_data_q <= rif.bus_resp_data;
      end
    end
  end

  assign rif.cw_valid = cw_valid_q;
  assign rif.cw_data  = cw_data_q;
`else
  assign rif.cw_valid = 1'b0;
  assign rif.cw_data  = '0;
`endif

  assign req_addr_full = beat_addr(64'(base_q), 64'(beat_q), WORD_SH);

  assign rif.miss_ready    = miss_ready_q;
  assign rif.bus_req_valid = req_valid_q;
  assign rif.bus_req_addr  = req_addr_full[ADDR_W-1:0];
  assign rif.ram_we        = ram_we_q;
  assign rif.fill_done     = ram_we_q;
  assign rif.ram_a         = index_q;
  assign rif.ram_di        = buf_q;

  // Offset bits of the miss address and the widened address tail carry no state.
  assign unused_bits = ^{req_addr_full[63:ADDR_W], rif.miss_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_line_refill.sv
// Directed bench for line_refill: a small bus responder returns salt+word
// slot for every read, logs requests, line writes and critical-word pulses,
// and the main sequence checks them against hand-computed values.
// Build option: LINE_REFILL_CWF_EN selects critical-word-first expectations.
module tb_line_refill;
  import refill_pkg::*;

`ifdef LINE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc;

  line_refill_if rif ();

  line_refill dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rif   (rif)
  );

  int n_tests;
  int n_fail;

  // responder / log state
  logic [31:0] salt;
  int          stall_left;
  bit          spur_en;
  bit          pend;
  logic [31:0] pend_addr;
  bit          prev_unacc;
  logic [31:0] prev_addr;
  int          resp_cnt;
  int          cw_cnt;
  logic [31:0] cw_last;
  logic [31:0]  req_log[$];
  int           wr_cyc[$];
  logic [6:0]   wr_a[$];
  logic [127:0] wr_di[$];
  logic         wr_fd[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] s);
    return {s + 32'd3, s + 32'd2, s + 32'd1, s};
  endfunction

  task automatic clear_logs();
    req_log.delete();
    wr_cyc.delete();
    wr_a.delete();
    wr_di.delete();
    wr_fd.delete();
    resp_cnt = 0;
    cw_cnt   = 0;
    cw_last  = '0;
  endtask

  // Bus responder and output logger, all decisions at the falling edge.
  initial begin
    rif.bus_req_ready  = 1'b1;
    rif.bus_resp_valid = 1'b0;
    rif.bus_resp_data  = '0;
    pend = 1'b0;
    prev_unacc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        prev_unacc = 1'b0;
        rif.bus_resp_valid = 1'b0;
        rif.bus_req_ready  = 1'b1;
      end else begin
        if (pend) begin
          rif.bus_resp_valid = 1'b1;
          rif.bus_resp_data  = salt + 32'(pend_addr[3:2]);
          resp_cnt++;
          pend = 1'b0;
        end else if (spur_en && rif.bus_req_valid && stall_left > 0) begin
          rif.bus_resp_valid = 1'b1;
          rif.bus_resp_data  = 32'hDEAD_BEEF;
        end else begin
          rif.bus_resp_valid = 1'b0;
        end
        if (rif.bus_req_valid) begin
          if (prev_unacc) chk("req_addr_stable", rif.bus_req_addr, prev_addr);
          prev_addr = rif.bus_req_addr;
          if (stall_left > 0) begin
            rif.bus_req_ready = 1'b0;
            stall_left--;
            prev_unacc = 1'b1;
          end else begin
            rif.bus_req_ready = 1'b1;
            req_log.push_back(rif.bus_req_addr);
            pend = 1'b1;
            pend_addr = rif.bus_req_addr;
            prev_unacc = 1'b0;
          end
        end else begin
          rif.bus_req_ready = 1'b1;
          prev_unacc = 1'b0;
        end
        if (rif.ram_we) begin
          wr_cyc.push_back(cyc);
          wr_a.push_back(rif.ram_a);
          wr_di.push_back(rif.ram_di);
          wr_fd.push_back(rif.fill_done);
        end
        if (rif.cw_valid) begin
          cw_cnt++;
          cw_last = rif.cw_data;
        end
      end
    end
  end

  task automatic do_miss(input logic [31:0] a, output int t0);
    @(negedge clk); #1;
    rif.miss_addr  = a;
    rif.miss_valid = 1'b1;
    t0 = cyc;
    chk("miss_ready_idle", rif.miss_ready, 1'b1);
    @(negedge clk); #1;
    rif.miss_valid = 1'b0;
  endtask

  task automatic wait_write(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (wr_a.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(tag, wr_a.size() >= n, 1'b1);
  endtask

  task automatic check_fill(input string tag, input int t0, input int lat,
                            input logic [6:0] idx, input logic [31:0] s);
    if (wr_a.size() >= 1) begin
      chk({tag, "_lat"}, wr_cyc[0] - t0, lat);
      chk({tag, "_ram_a"}, wr_a[0], idx);
      chk({tag, "_ram_di"}, wr_di[0], exp_line(s));
      chk({tag, "_fill_done"}, wr_fd[0], 1'b1);
      chk({tag, "_one_write"}, wr_a.size(), 1);
      chk({tag, "_req_cnt"}, req_log.size(), 4);
    end
  endtask

  logic [31:0] seq2 [4];
  logic [31:0] cwf2 [4];
  logic [31:0] seq3 [4];
  logic [31:0] cwf3 [4];

  initial begin : main
    int t0;
    int t1;
    int k;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    salt    = '0;
    stall_left = 0;
    spur_en = 1'b0;
    rst_n   = 1'b1;
    rif.miss_valid = 1'b0;
    rif.miss_addr  = '0;
    seq2 = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
    cwf2 = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
    seq3 = '{32'h10, 32'h14, 32'h18, 32'h1C};
    cwf3 = '{32'h18, 32'h1C, 32'h10, 32'h14};
    clear_logs();

    // 1: reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_miss_ready", rif.miss_ready, 1'b1);
    chk("rst_ram_we", rif.ram_we, 1'b0);
    chk("rst_bus_req_valid", rif.bus_req_valid, 1'b0);
    chk("rst_ram_di", rif.ram_di, '0);
    chk("rst_fill_done", rif.fill_done, 1'b0);
    chk("rst_cw_valid", rif.cw_valid, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // 2: miss 0x1234, zero-wait bus
    clear_logs();
    salt = 32'hA0;
    do_miss(32'h0000_1234, t0);
    wait_write("t2_write_seen", 1, 40);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_req%0d", i), (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF,
          CWF ? cwf2[i] : seq2[i]);
    check_fill("t2", t0, 9, 7'h23, 32'hA0);
    @(negedge clk); #1;
    chk("t2_cw_cnt", cw_cnt, CWF ? 1 : 0);
    chk("t2_cw_data", cw_last, CWF ? 32'hA1 : 32'h0);
    chk("t2_ready_after_write", rif.miss_ready, 1'b1);

    // 3: miss 0x18, start beat 2 in the critical-word-first build
    clear_logs();
    salt = 32'h5500;
    do_miss(32'h0000_0018, t0);
    wait_write("t3_write_seen", 1, 40);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_req%0d", i), (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF,
          CWF ? cwf3[i] : seq3[i]);
    check_fill("t3", t0, 9, 7'h01, 32'h5500);
    @(negedge clk); #1;
    chk("t3_cw_cnt", cw_cnt, CWF ? 1 : 0);
    chk("t3_cw_data", cw_last, CWF ? 32'h5502 : 32'h0);

    // 4: first request held off 3 cycles with a spurious response meanwhile
    clear_logs();
    salt = 32'h7700;
    stall_left = 3;
    spur_en = 1'b1;
    do_miss(32'h0000_2040, t0);
    wait_write("t4_write_seen", 1, 40);
    spur_en = 1'b0;
    chk("t4_req0", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h2040);
    check_fill("t4", t0, 12, 7'h04, 32'h7700);

    // 5: reset after two beats discards the fill
    @(negedge clk); #1;
    clear_logs();
    salt = 32'h3300;
    do_miss(32'h0000_4470, t0);
    k = 0;
    while (resp_cnt < 2 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk("t5_two_beats_seen", resp_cnt >= 2, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_req_valid", rif.bus_req_valid, 1'b0);
    chk("t5_rst_miss_ready", rif.miss_ready, 1'b1);
    chk("t5_rst_ram_we", rif.ram_we, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("t5_buf_cleared", rif.ram_di, '0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
    end
    chk("t5_no_write", wr_a.size(), 0);
    chk("t5_no_more_req", req_log.size(), 3);
    clear_logs();
    salt = 32'h4400;
    do_miss(32'h0000_4470, t0);
    wait_write("t5_refill_seen", 1, 40);
    check_fill("t5", t0, 9, 7'h47, 32'h4400);

    // 6: miss_valid held through WRITE gives back-to-back fills
    @(negedge clk); #1;
    clear_logs();
    salt = 32'h6600;
    rif.miss_addr  = 32'h0000_08C0;
    rif.miss_valid = 1'b1;
    t0 = cyc;
    wait_write("t6_first_write", 1, 40);
    chk("t6_ready_in_write", rif.miss_ready, 1'b0);
    rif.miss_addr = 32'h0000_0950;
    salt = 32'h6700;
    @(negedge clk); #1;
    chk("t6_ready_after_write", rif.miss_ready, 1'b1);
    t1 = cyc;
    @(negedge clk); #1;
    rif.miss_valid = 1'b0;
    chk("t6_second_accepted", rif.bus_req_valid, 1'b1);
    wait_write("t6_second_write", 2, 40);
    if (wr_a.size() >= 2) begin
      chk("t6_lat1", wr_cyc[0] - t0, 9);
      chk("t6_lat2", wr_cyc[1] - t1, 9);
      chk("t6_gap", wr_cyc[1] - wr_cyc[0], 10);
      chk("t6_ram_a0", wr_a[0], 7'h0C);
      chk("t6_ram_a1", wr_a[1], 7'h15);
      chk("t6_ram_di0", wr_di[0], exp_line(32'h6600));
      chk("t6_ram_di1", wr_di[1], exp_line(32'h6700));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
